// File: rtl/lieat_axi_master.sv
// Single-outstanding AXI4 initiator: turns one valid/ready memory request into
// one single-beat AXI read or write and returns the checked result.
module lieat_axi_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [2:0]  size_reg, size_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic req_illegal;
  logic rd_err;
  logic wr_err;

  // Misaligned halfword/word accesses and undefined sizes never reach the bus.
  assign req_illegal = (req_size > 3'd2) ||
                       ((req_size == 3'd1) && req_addr[0]) ||
                       ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
  assign rd_err = (io_master_rresp != 2'b00) || !io_master_rlast || (io_master_rid != AXI_ID);
  assign wr_err = (io_master_bresp != 2'b00) || (io_master_bid != AXI_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      size_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      size_reg    <= size_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    size_next    = size_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = req_addr;
          size_next  = req_size;
          wdata_next = req_wdata;
          wstrb_next = req_wstrb;
          if (req_illegal) begin
            err_next   = 1'b1;
            rdata_next = '0;
            state_next = RSP;
          end else if (req_write) begin
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (io_master_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (io_master_rvalid) begin
          err_next   = rd_err;
          rdata_next = rd_err ? 32'd0 : io_master_rdata;
          state_next = RSP;
        end
      end
      WR_REQ: begin
        // Address and data channels complete independently, possibly together.
        aw_done_next = aw_done_reg | io_master_awready;
        w_done_next  = w_done_reg | io_master_wready;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (io_master_bvalid) begin
          err_next   = wr_err;
          rdata_next = '0;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RSP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  assign io_master_awvalid = (state_reg == WR_REQ) && !aw_done_reg;
  assign io_master_awaddr  = addr_reg;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_reg;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = (state_reg == WR_REQ) && !w_done_reg;
  assign io_master_wdata   = wdata_reg;
  assign io_master_wstrb   = {4'b0000, wstrb_reg};
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state_reg == WR_RESP);
  assign io_master_arvalid = (state_reg == RD_ADDR);
  assign io_master_araddr  = addr_reg;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size_reg;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = (state_reg == RD_DATA);

endmodule

// File: tb/tb_lieat_axi_master.sv
// Directed bench for lieat_axi_master: each task drives one scenario cycle by
// cycle and compares outputs against hand-computed values.
module tb_lieat_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, bid, arid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int tests_run = 0;
  int tests_failed = 0;

  lieat_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d, input logic [3:0] b);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d; req_wstrb = b;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    tests_run++; if ({rsp_err, rsp_rdata} !== 33'd0) begin tests_failed++; $display("FAIL rst_rsp: got err=%b data=%h want 0/0", rsp_err, rsp_rdata); end
    tests_run++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin tests_failed++; $display("FAIL rst_axi_hs: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    tests_run++; if ({araddr, wdata, wstrb} !== 72'd0) begin tests_failed++; $display("FAIL rst_regs: got addr=%h wdata=%h wstrb=%h want 0", araddr, wdata, wstrb); end
    $display("[TB] reset checked");
  endtask

  task automatic test_read();
    start_req(1'b0, 32'h8000_0010, 3'd2, 32'h0, 4'h0);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_accept: got %b want 1", req_ready); end
    tick(); // cycle 1
    req_valid = 1'b0;
    tests_run++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin tests_failed++; $display("FAIL rd_ar: got v=%b addr=%h want 1/80000010", arvalid, araddr); end
    tests_run++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd0, 3'd2, 2'd1}) begin tests_failed++; $display("FAIL rd_ar_fields: got id=%h len=%h size=%h burst=%h want 0/0/2/1", arid, arlen, arsize, arburst); end
    tests_run++; if (rready !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL rd_c1_ready: got rready=%b req_ready=%b want 0/0", rready, req_ready); end
    arready = 1'b1;
    tick(); // cycle 2
    arready = 1'b0;
    tests_run++; if (arvalid !== 1'b0 || rready !== 1'b1) begin tests_failed++; $display("FAIL rd_c2: got arvalid=%b rready=%b want 0/1", arvalid, rready); end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1'b1; rid = 4'h0;
    tick(); // cycle 3
    rvalid = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rd_rsp: got v=%b data=%h err=%b want 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
    finish_rsp();
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_done: got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
    $display("[TB] read 80000010 -> deadbeef");
  endtask

  task automatic test_write_split();
    start_req(1'b1, 32'h8000_0004, 3'd1, 32'h1234_5678, 4'b1100);
    tick(); // cycle 1
    req_valid = 1'b0;
    tests_run++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_c1_valid: got aw=%b w=%b want 1/1", awvalid, wvalid); end
    tests_run++; if (awaddr !== 32'h8000_0004 || wdata !== 32'h1234_5678 || wstrb !== 8'h0C) begin tests_failed++; $display("FAIL wr_payload: got addr=%h data=%h strb=%h want 80000004/12345678/0c", awaddr, wdata, wstrb); end
    tests_run++; if ({awid, awlen, awsize, awburst, wlast} !== {4'd0, 8'd0, 3'd1, 2'd1, 1'b1}) begin tests_failed++; $display("FAIL wr_fields: got id=%h len=%h size=%h burst=%h last=%b", awid, awlen, awsize, awburst, wlast); end
    wready = 1'b1;
    tick(); // cycle 2
    wready = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tests_run++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin tests_failed++; $display("FAIL wr_hold_c%0d: got w=%b aw=%b bready=%b want 0/1/0", c, wvalid, awvalid, bready); end
      if (c == 4) awready = 1'b1;
      tick();
    end
    awready = 1'b0; // cycle 5
    tests_run++; if (awvalid !== 1'b0 || bready !== 1'b1) begin tests_failed++; $display("FAIL wr_c5: got aw=%b bready=%b want 0/1", awvalid, bready); end
    bvalid = 1'b1; bresp = 2'b00; bid = 4'h0;
    tick();
    bvalid = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rsp: got v=%b err=%b data=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    finish_rsp();
    $display("[TB] write 80000004 split handshakes");
  endtask

  task automatic test_write_min_err();
    start_req(1'b1, 32'h8000_0100, 3'd2, 32'hCAFE_F00D, 4'hF);
    tick(); // cycle 1
    req_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    tick(); // cycle 2
    awready = 1'b0; wready = 1'b0;
    tests_run++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin tests_failed++; $display("FAIL wrmin_c2: got aw=%b w=%b bready=%b want 0/0/1", awvalid, wvalid, bready); end
    bvalid = 1'b1; bresp = 2'b11; bid = 4'h0;
    tick(); // cycle 3
    bvalid = 1'b0; bresp = 2'b00;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL wrmin_rsp: got v=%b err=%b want 1/1", rsp_valid, rsp_err); end
    finish_rsp();
    $display("[TB] write 80000100 bresp=3 -> err");
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0011};
    logic [2:0]  sizes [3] = '{3'd2, 3'd3, 3'd1};
    logic        wrs   [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      start_req(wrs[k], addrs[k], sizes[k], 32'hFFFF_FFFF, 4'hF);
      tick(); // cycle 1
      req_valid = 1'b0;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL ill%0d_rsp: got v=%b err=%b data=%h want 1/1/0", k, rsp_valid, rsp_err, rsp_rdata); end
      tests_run++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin tests_failed++; $display("FAIL ill%0d_bus: got ar=%b aw=%b w=%b want 000", k, arvalid, awvalid, wvalid); end
      finish_rsp();
      tests_run++; if (arvalid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL ill%0d_after: got ar=%b req_ready=%b want 0/1", k, arvalid, req_ready); end
      $display("[TB] illegal addr=%h size=%0d -> err", addrs[k], sizes[k]);
    end
  endtask

  task automatic test_read_errors();
    logic [1:0] rr [2] = '{2'b10, 2'b00};
    logic [3:0] ri [2] = '{4'h0, 4'hF};
    for (int k = 0; k < 2; k++) begin
      start_req(1'b0, 32'h8000_0040, 3'd2, 32'h0, 4'h0);
      tick();
      req_valid = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hAAAA_5555; rresp = rr[k]; rlast = 1'b1; rid = ri[k];
      tick();
      rvalid = 1'b0; rresp = 2'b00; rid = 4'h0;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rderr%0d: got v=%b err=%b data=%h want 1/1/0", k, rsp_valid, rsp_err, rsp_rdata); end
      finish_rsp();
      $display("[TB] read error case %0d (rresp=%0d rid=%h)", k, rr[k], ri[k]);
    end
  endtask

  task automatic test_back_to_back();
    start_req(1'b0, 32'h8000_0008, 3'd2, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b00; rlast = 1'b1; rid = 4'h0;
    tick(); // in RSP
    rvalid = 1'b0;
    start_req(1'b0, 32'h8000_0020, 3'd2, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || req_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold%0d: got v=%b data=%h req_ready=%b want 1/0badf00d/0", c, rsp_valid, rsp_rdata, req_ready); end
      tick();
    end
    finish_rsp();
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid); end
    tick();
    req_valid = 1'b0;
    tests_run++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0020) begin tests_failed++; $display("FAIL b2b_second: got ar=%b addr=%h want 1/80000020", arvalid, araddr); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_2222;
    tick();
    rvalid = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_2222 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_rsp2: got v=%b data=%h err=%b want 1/11112222/0", rsp_valid, rsp_rdata, rsp_err); end
    finish_rsp();
    $display("[TB] back-to-back reads with stalled response");
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 32'h8000_0030, 3'd2, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0; arready = 1'b1;
    tick(); // RD_DATA
    arready = 1'b0;
    tests_run++; if (rready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_rready: got %b want 1", rready); end
    rst = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; rvalid = 1'b0;
    tests_run++; if ({rready, arvalid, rsp_valid, req_ready} !== 4'b0001) begin tests_failed++; $display("FAIL rstmid_out: got rready=%b ar=%b rsp_valid=%b req_ready=%b want 0/0/0/1", rready, arvalid, rsp_valid, req_ready); end
    tests_run++; if (rsp_rdata !== 32'h0 || araddr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_regs: got data=%h addr=%h want 0/0", rsp_rdata, araddr); end
    start_req(1'b0, 32'h8000_0034, 3'd2, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0; arready = 1'b1;
    tests_run++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0034) begin tests_failed++; $display("FAIL rstmid_ar: got ar=%b addr=%h want 1/80000034", arvalid, araddr); end
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h5A5A_1234; rresp = 2'b00; rlast = 1'b1; rid = 4'h0;
    tick();
    rvalid = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A_1234 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rsp: got v=%b data=%h err=%b want 1/5a5a1234/0", rsp_valid, rsp_rdata, rsp_err); end
    finish_rsp();
    $display("[TB] reset during RD_DATA then read 80000034");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0; rlast = 1'b0; rid = '0;
    test_reset();
    test_read();
    test_write_split();
    test_write_min_err();
    test_illegal();
    test_read_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lieat_axi_master.md
# lieat_axi_master

Initiator-side AXI4 bridge between the core's load/store/fetch request port and the `io_master_*` bus that the SoC's AXI slave and SRAM sit behind. It accepts one simple valid/ready memory request, issues exactly one single-beat AXI4 read or write, checks the response, and returns it on a valid/ready response port. Only one transaction is outstanding at a time.

## Interface
- `AXI_ID`, default 4'd0: value driven on `io_master_arid` and `io_master_awid`; expected on `rid` and `bid`.
- `clk` input 1: sole clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid & req_ready`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 32: byte address.
- `req_size` input 3: 0 = byte, 1 = half, 2 = word; 3..7 illegal.
- `req_wdata` input 32: write data, already lane-aligned.
- `req_wstrb` input 4: byte strobes.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` output 32: read data; 0 for writes and errors.
- `rsp_err` output 1: bus or request error.
- `io_master_aw*`, output except `awready`: `awvalid` 1, `awready` 1, `awaddr` 32, `awid` 4, `awlen` 8, `awsize` 3, `awburst` 2.
- `io_master_w*`, output except `wready`: `wvalid` 1, `wready` 1, `wdata` 32, `wstrb` 8, `wlast` 1.
- `io_master_b*`, output `bready` 1; inputs `bvalid` 1, `bresp` 2, `bid` 4.
- `io_master_ar*`, output except `arready`: `arvalid` 1, `arready` 1, `araddr` 32, `arid` 4, `arlen` 8, `arsize` 3, `arburst` 2.
- `io_master_r*`, output `rready` 1; inputs `rvalid` 1, `rresp` 2, `rdata` 32, `rlast` 1, `rid` 4.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - `req_ready` = 1 only in IDLE.
  - On accept, register `addr`, `size`, `wdata` and `wstrb`.
  - An illegal request goes to RSP with `rsp_err`=1 and issues no AXI traffic. A request is illegal when `size` > 2, or `size`=1 with `addr[0]`=1, or `size`=2 with `addr[1:0]`≠0.
  - Otherwise a read goes to RD_ADDR and a write goes to WR_REQ.
- RD_ADDR: `arvalid`=1, with `araddr` and `arsize` stable. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata` and go to RSP.
  - Error = `rresp`≠0, or `rlast`=0, or `rid`≠`AXI_ID`.
  - On error, `rsp_rdata` = 0.
- WR_REQ:
  - `awvalid` and `wvalid` both assert on entry.
  - Each deasserts independently after its own handshake, tracked by `aw_done` and `w_done` flags.
  - Go to WR_RESP in the cycle both handshakes are complete, including when both complete in the same cycle.
- WR_RESP: `bready`=1. On `bvalid`, go to RSP. Error = `bresp`≠0 or `bid`≠`AXI_ID`.
- RSP: `rsp_valid`=1 with `rsp_rdata` and `rsp_err` stable. On `rsp_ready`, go to IDLE.
- Constant fields: `awlen`=`arlen`=0, `awburst`=`arburst`=2'b01 (INCR), `wlast`=1.
- Write data lanes: `wstrb[3:0]`=`req_wstrb`, `wstrb[7:4]`=0.
- `awsize` and `arsize` = registered `size`.
- Address fields carry the registered address unmodified.
- All AXI valid outputs and `bready`/`rready` are driven from state or flip-flops; no combinational path from an AXI input to an AXI output.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0. All AXI valid and ready outputs are 0, and the address/data registers are 0.
- Reset mid-transaction: outputs return to their reset values on the next edge. No pending beat is completed.
- Accept is at cycle 0, and `arvalid`/`awvalid`/`wvalid` are first high at cycle 1.
- Minimum read: with `arready`=1 at cycle 1 and `rvalid` at cycle 2, `rsp_valid` is high at cycle 3.
- Minimum write: with `awready`=`wready`=1 at cycle 1 and `bvalid` at cycle 2, `rsp_valid` is high at cycle 3.
- Illegal request: `rsp_valid` at cycle 1.
- Once asserted, a valid stays high with stable payload until its handshake. There is no retraction.
- Back-to-back: a new request can be accepted the cycle after the response handshake. Peak rate is one transaction per 4 cycles.
- `rsp_ready` held low: the block stays in RSP and `req_ready` stays 0.

## Test plan
- Read 0x8000_0010, size 2, `arready` at cycle 1, `rvalid` at cycle 2 with `rdata`=0xDEAD_BEEF, `rresp`=0, `rlast`=1 -> `arid`=`AXI_ID`, `arlen`=0, `arburst`=1; `rsp_valid` at cycle 3 with `rdata`=0xDEAD_BEEF, `err`=0.
- Write 0x8000_0004 with `wdata`=0x1234_5678, `wstrb`=4'b1100, size 1; `wready` at cycle 1, `awready` at cycle 4 -> `wvalid` drops after cycle 1 and `awvalid` is held to cycle 4. The bus sees `wstrb`=8'h0C. `bresp`=0 -> `rsp_err`=0.
- Word read at address 0x8000_0002 -> no `arvalid` ever; `rsp_valid` at cycle 1 with `err`=1, `rdata`=0. Same behaviour with `req_size`=3.
- Read returning `rresp`=2'b10, then a read returning `rid`=4'hF with `AXI_ID`=0 -> `rsp_err`=1 and `rdata`=0 both times.
- `rsp_ready` held low for 5 cycles with `req_valid` held high -> `rsp_valid` and data stay stable and `req_ready` stays 0. The second request is accepted the cycle after `rsp_ready` rises.
- `rst` pulsed while in RD_DATA -> next cycle `rready`=0, `arvalid`=0, `rsp_valid`=0, `req_ready`=1. The following read completes normally.
